// File: rtl/tdp_ram_be.sv
// tdp_ram_be: true dual-port byte-enable RAM with clear sequencer; define TDP_RAM_COLL_CNT_EN for coll_cnt
module tdp_ram_be #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  output logic                    busy,
  input  logic                    en_a,
  input  logic                    we_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   data_a,
  output logic [DATA_WIDTH-1:0]   q_a,
  output logic                    qv_a,
  input  logic                    en_b,
  input  logic                    we_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   data_b,
  output logic [DATA_WIDTH-1:0]   q_b,
  output logic                    qv_b,
  output logic                    coll
`ifdef TDP_RAM_COLL_CNT_EN
  ,
  output logic [15:0]             coll_cnt
`endif
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b, d1_a, d1_b, q1_a, q1_b;
  logic acc_a, acc_b, wr_a, wr_b, v1_a, v1_b, r1_a, r1_b, coll_ev;
  // access qualification, old/merged words and the data each port returns
  always_comb begin
    acc_a = (state == READY) & en_a;
    acc_b = (state == READY) & en_b;
    wr_a = acc_a & we_a;
    wr_b = acc_b & we_b;
    old_a = mem[addr_a];
    old_b = mem[addr_b];
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < NB; i++) begin
      new_a[8*i+:8] = be_a[i] ? data_a[8*i+:8] : old_a[8*i+:8];
      new_b[8*i+:8] = be_b[i] ? data_b[8*i+:8] : old_b[8*i+:8];
    end
    d1_a = (wr_a && RDW_MODE == 1) ? new_a : old_a;
    d1_b = (wr_b && RDW_MODE == 1) ? new_b : old_b;
    v1_a = acc_a & (~we_a | (RDW_MODE != 2));
    v1_b = acc_b & (~we_b | (RDW_MODE != 2));
    coll_ev = wr_a & wr_b & (addr_a == addr_b);
  end
  // array update: sweep zeroes while clearing, else B lanes then A lanes so A wins on its own lanes
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[cnt] <= '0;
    else
      for (int i = 0; i < NB; i++) begin
        if (wr_b && be_b[i]) mem[addr_b][8*i+:8] <= data_b[8*i+:8];
        if (wr_a && be_a[i]) mem[addr_a][8*i+:8] <= data_a[8*i+:8];
      end
  end
  // clear sequencer, first read stage and collision pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
      busy <= 1'b1;
      coll <= 1'b0;
      r1_a <= 1'b0;
      r1_b <= 1'b0;
      q1_a <= '0;
      q1_b <= '0;
    end else begin
      if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          state <= READY;
          busy <= 1'b0;
        end
      end else if (clr) begin
        state <= CLEAR;
        cnt <= '0;
        busy <= 1'b1;
      end
      r1_a <= v1_a;
      r1_b <= v1_b;
      if (v1_a) q1_a <= d1_a;
      if (v1_b) q1_b <= d1_b;
      coll <= coll_ev;
    end
  end
  if (OUT_REG != 0) begin : g_oreg
    // extra output stage that holds q until new valid data arrives
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_a <= '0;
        q_b <= '0;
        qv_a <= 1'b0;
        qv_b <= 1'b0;
      end else begin
        qv_a <= r1_a;
        qv_b <= r1_b;
        if (r1_a) q_a <= q1_a;
        if (r1_b) q_b <= q1_b;
      end
    end
  end else begin : g_direct
    assign q_a = q1_a;
    assign q_b = q1_b;
    assign qv_a = r1_a;
    assign qv_b = r1_b;
  end
`ifdef TDP_RAM_COLL_CNT_EN
  // saturating collision counter, cleared with the array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) coll_cnt <= '0;
    else if (state == READY && clr) coll_cnt <= '0;
    else if (coll_ev && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_tdp_ram_be.sv
// tb_tdp_ram_be: directed checks of tdp_ram_be across RDW modes and output register
module tb_tdp_ram_be;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, clr = 0, en_a = 0, we_a = 0, en_b = 0, we_b = 0;
  logic [3:0] be_a = 0, be_b = 0;
  logic [5:0] addr_a = 0, addr_b = 0;
  logic [31:0] data_a = 0, data_b = 0;
  logic [31:0] q_a [4];
  logic [31:0] q_b [4];
  logic [3:0] qv_a, qv_b, busy, coll;
  int total = 0, bad = 0;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    tdp_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .RDW_MODE(k == 3 ? 0 : k), .OUT_REG(k == 3 ? 1 : 0)) dut (
      .clk(clk), .rst(rst), .clr(clr), .busy(busy[k]),
      .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a[k]), .qv_a(qv_a[k]),
      .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b[k]), .qv_b(qv_b[k]),
      .coll(coll[k])
    );
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    en_a = 0; we_a = 0; be_a = 0; en_b = 0; we_b = 0; be_b = 0;
  endtask

  task automatic wr_a(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    en_a = 1; we_a = 1; addr_a = a; data_a = d; be_a = be;
  endtask

  task automatic wr_b(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    en_b = 1; we_b = 1; addr_b = a; data_b = d; be_b = be;
  endtask

  task automatic rd_a(input logic [5:0] a);
    en_a = 1; we_a = 0; addr_a = a; be_a = 0;
  endtask

  task automatic rd_b(input logic [5:0] a);
    en_b = 1; we_b = 0; addr_b = a; be_b = 0;
  endtask

  task automatic test_reset;
    int n;
    logic [5:0] addrs [3];
    addrs = '{6'h00, 6'h2A, 6'h3F};
    tick;
    total++; if (busy !== 4'hF) begin bad++; $display("FAIL rst_busy got=%b exp=1111", busy); end
    total++; if ({qv_a, qv_b, coll} !== 12'h0) begin bad++; $display("FAIL rst_flags got=%h exp=000", {qv_a, qv_b, coll}); end
    total++; if (q_a[0] !== 32'h0 || q_b[3] !== 32'h0) begin bad++; $display("FAIL rst_q got=%h/%h exp=0", q_a[0], q_b[3]); end
    rst = 0;
    n = 0;
    while (busy[0] && n < 200) begin tick; n++; end
    total++; if (n !== 64) begin bad++; $display("FAIL sweep_len got=%0d exp=64", n); end
    total++; if (busy !== 4'h0) begin bad++; $display("FAIL sweep_done got=%b exp=0000", busy); end
    foreach (addrs[i]) begin
      rd_a(addrs[i]); rd_b(addrs[i]);
      tick;
      total++; if (q_a[0] !== 32'h0 || qv_a[0] !== 1'b1) begin bad++; $display("FAIL zero_rd_a addr=%h got=%h v=%b exp=0 v=1", addrs[i], q_a[0], qv_a[0]); end
      total++; if (q_b[0] !== 32'h0 || qv_b[0] !== 1'b1) begin bad++; $display("FAIL zero_rd_b addr=%h got=%h v=%b exp=0 v=1", addrs[i], q_b[0], qv_b[0]); end
    end
    idle;
    tick;
    total++; if (qv_a[0] !== 1'b0 || qv_b[0] !== 1'b0) begin bad++; $display("FAIL qv_pulse got=%b%b exp=00", qv_a[0], qv_b[0]); end
  endtask

  task automatic test_byte_en;
    wr_a(6'd5, 32'hAABBCCDD, 4'b1111);
    tick;
    wr_a(6'd5, 32'h11223344, 4'b0101);
    tick;
    total++; if (q_a[0] !== 32'hAABBCCDD || qv_a[0] !== 1'b1) begin bad++; $display("FAIL be_rdw0 got=%h v=%b exp=aabbccdd v=1", q_a[0], qv_a[0]); end
    total++; if (q_a[1] !== 32'hAA22CC44) begin bad++; $display("FAIL be_rdw1 got=%h exp=aa22cc44", q_a[1]); end
    idle; rd_b(6'd5);
    tick;
    total++; if (q_b[0] !== 32'hAA22CC44 || qv_b[0] !== 1'b1) begin bad++; $display("FAIL be_merge got=%h v=%b exp=aa22cc44 v=1", q_b[0], qv_b[0]); end
    idle;
  endtask

  task automatic test_rdw;
    rd_a(6'd5);
    tick;
    total++; if (q_a[2] !== 32'hAA22CC44) begin bad++; $display("FAIL rdw_pre got=%h exp=aa22cc44", q_a[2]); end
    wr_a(6'd3, 32'h10, 4'hF);
    tick;
    total++; if (q_a[0] !== 32'h0 || qv_a[2] !== 1'b0) begin bad++; $display("FAIL rdw_first got=%h v2=%b exp=0 v2=0", q_a[0], qv_a[2]); end
    wr_a(6'd3, 32'h20, 4'hF);
    tick;
    total++; if (q_a[0] !== 32'h10 || qv_a[0] !== 1'b1) begin bad++; $display("FAIL rdw_mode0 got=%h v=%b exp=10 v=1", q_a[0], qv_a[0]); end
    total++; if (q_a[1] !== 32'h20 || qv_a[1] !== 1'b1) begin bad++; $display("FAIL rdw_mode1 got=%h v=%b exp=20 v=1", q_a[1], qv_a[1]); end
    total++; if (q_a[2] !== 32'hAA22CC44 || qv_a[2] !== 1'b0) begin bad++; $display("FAIL rdw_mode2 got=%h v=%b exp=aa22cc44 v=0", q_a[2], qv_a[2]); end
    rd_a(6'd3);
    tick;
    for (int k = 0; k < 3; k++) begin
      total++; if (q_a[k] !== 32'h20 || qv_a[k] !== 1'b1) begin bad++; $display("FAIL rdw_after%0d got=%h v=%b exp=20 v=1", k, q_a[k], qv_a[k]); end
    end
    wr_a(6'd3, 32'h30, 4'hF); rd_b(6'd3);
    tick;
    total++; if (q_b[0] !== 32'h20 || qv_b[0] !== 1'b1) begin bad++; $display("FAIL cross_old got=%h v=%b exp=20 v=1", q_b[0], qv_b[0]); end
    idle;
  endtask

  task automatic test_coll;
    wr_a(6'd9, 32'h1111, 4'b0001); wr_b(6'd9, 32'h2222, 4'b0011);
    tick;
    total++; if (coll !== 4'hF) begin bad++; $display("FAIL coll_pulse got=%b exp=1111", coll); end
    idle;
    tick;
    total++; if (coll !== 4'h0) begin bad++; $display("FAIL coll_end got=%b exp=0000", coll); end
    rd_a(6'd9);
    tick;
    total++; if (q_a[0] !== 32'h2211) begin bad++; $display("FAIL coll_data got=%h exp=2211", q_a[0]); end
    wr_a(6'd9, 32'h5C, 4'hF); wr_b(6'd10, 32'h77, 4'hF);
    tick;
    total++; if (coll !== 4'h0) begin bad++; $display("FAIL coll_diff got=%b exp=0000", coll); end
    idle;
  endtask

  task automatic test_out_reg;
    int nv;
    wr_a(6'd7, 32'h5A, 4'hF); tick;
    wr_a(6'd8, 32'h5B, 4'hF); tick;
    idle; tick; tick;
    rd_a(6'd7);
    tick;
    total++; if (qv_a[3] !== 1'b0) begin bad++; $display("FAIL oreg_early got=%b exp=0", qv_a[3]); end
    idle;
    tick;
    total++; if (q_a[3] !== 32'h5A || qv_a[3] !== 1'b1) begin bad++; $display("FAIL oreg_lat got=%h v=%b exp=5a v=1", q_a[3], qv_a[3]); end
    tick;
    total++; if (qv_a[3] !== 1'b0 || q_a[3] !== 32'h5A) begin bad++; $display("FAIL oreg_hold got=%h v=%b exp=5a v=0", q_a[3], qv_a[3]); end
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) rd_a(6'(7 + i)); else idle;
      tick;
      if (qv_a[3]) nv++;
      if (i >= 1 && i <= 3) begin
        total++; if (q_a[3] !== 32'(32'h59 + i) || qv_a[3] !== 1'b1) begin bad++; $display("FAIL oreg_b2b%0d got=%h v=%b exp=%h v=1", i, q_a[3], qv_a[3], 32'h59 + i); end
      end
    end
    total++; if (nv !== 3) begin bad++; $display("FAIL oreg_count got=%0d exp=3", nv); end
  endtask

  task automatic test_clr;
    int n;
    wr_a(6'd12, 32'hFF, 4'hF);
    tick;
    idle; clr = 1;
    tick;
    clr = 0;
    rd_b(6'd12);
    n = 0;
    while (busy[0] && n < 200) begin
      tick; n++;
      if (n == 1) begin
        total++; if (qv_b[0] !== 1'b0) begin bad++; $display("FAIL clr_qv got=%b exp=0", qv_b[0]); end
        idle;
      end
    end
    total++; if (n !== 64) begin bad++; $display("FAIL clr_len got=%0d exp=64", n); end
    rd_a(6'd12);
    tick;
    total++; if (q_a[0] !== 32'h0 || qv_a[0] !== 1'b1) begin bad++; $display("FAIL clr_zero got=%h v=%b exp=0 v=1", q_a[0], qv_a[0]); end
    wr_a(6'd12, 32'hFF, 4'hF);
    tick;
    idle; clr = 1;
    tick;
    clr = 0;
    repeat (29) tick;
    rst = 1;
    tick;
    total++; if (busy !== 4'hF) begin bad++; $display("FAIL rst_mid_busy got=%b exp=1111", busy); end
    rst = 0;
    n = 0;
    while (busy[0] && n < 200) begin tick; n++; end
    total++; if (n !== 64) begin bad++; $display("FAIL rst_mid_len got=%0d exp=64", n); end
    rd_b(6'd12);
    tick;
    total++; if (q_b[0] !== 32'h0 || qv_b[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_zero got=%h v=%b exp=0 v=1", q_b[0], qv_b[0]); end
    idle;
  endtask

  initial begin
    test_reset;
    test_byte_en;
    test_rdw;
    test_coll;
    test_out_reg;
    test_clr;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tdp_ram_be.md
Name: tdp_ram_be

Overview:
- Parametrised true dual-port synchronous RAM; successor to the basic two-port RAM.
- Adds the following over the basic RAM:
  - per-byte write enables
  - selectable read-during-write mode
  - optional output pipeline register
  - per-port read-valid outputs
  - write-write collision detection with deterministic arbitration
  - hardware clear sequencer that zeroes the array after reset or on request
- Sits as the shared buffer between two independent masters in the memory subsystem.

Parameters:
- DATA_WIDTH, 8: word width in bits; must be a multiple of 8. NB = DATA_WIDTH/8 byte lanes.
- ADDR_WIDTH, 6: address width; DEPTH = 2**ADDR_WIDTH words.
- RDW_MODE, 0: same-port read-during-write behaviour. 0 = read-first (old data), 1 = write-first (new merged data), 2 = no-change (q holds, no valid pulse).
- OUT_REG, 0: 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles.

Ports:
- clk  in  1  rising-edge clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  single-cycle request to zero the whole array; honoured only when busy=0.
- busy  out  1  high while the clear sequencer runs; all port accesses are ignored while high.
- en_a  in  1  port A access enable.
- we_a  in  1  port A write (1) / read (0); qualified by en_a.
- be_a  in  NB  port A byte-lane enables for writes.
- addr_a  in  ADDR_WIDTH  port A address.
- data_a  in  DATA_WIDTH  port A write data.
- q_a  out  DATA_WIDTH  port A read data.
- qv_a  out  1  port A read-valid pulse, aligned with q_a.
- en_b, we_b, be_b, addr_b, data_b, q_b, qv_b: port B equivalents of the above.
- coll  out  1  one-cycle pulse when both ports write the same address in the same cycle.

Behaviour:
- Reset (async, rst=1):
  - q_a, q_b = 0; qv_a, qv_b, coll = 0; busy = 1.
  - Sequencer enters state CLEAR with address counter = 0.
  - The array is not reset asynchronously.
- State machine, two states:
  - CLEAR: each cycle writes 0 to mem[cnt] and increments cnt. After the DEPTH-1 write, go to READY; busy drops on the following edge. The sweep takes exactly DEPTH cycles after rst deasserts.
  - READY: normal operation. A clr pulse goes to CLEAR with cnt = 0 and sets busy on the next edge.
  - clr while in CLEAR is ignored.
  - rst asserted mid-sweep restarts the sweep from 0.
- In CLEAR: en_a and en_b are ignored; qv_a and qv_b stay 0; q_a and q_b hold their values.
- Write (en & we, READY): for each lane i with be[i]=1, mem[addr][8i+7:8i] <= data[8i+7:8i]. Lanes with be[i]=0 are unchanged. be = 0 means no write.
- Read (en & ~we, READY):
  - OUT_REG=0: q updates and qv pulses on the next edge.
  - OUT_REG=1: q and qv appear one edge later. The pipeline stage holds q when no new valid data enters; qv follows the pipeline.
- Same-port write with RDW_MODE 0 or 1:
  - The port also returns data with qv=1.
  - Mode 0: pre-write word. Mode 1: post-write merged word.
  - Mode 2: q holds and qv=0.
- Cross-port: a read on one port of an address being written by the other port in the same cycle returns the old word.
- Write-write collision: both ports write the same address in the same cycle.
  - Port A wins only on lanes where be_a=1; lanes enabled only by be_b take port B data.
  - coll pulses 1 cycle after the collision edge, independent of OUT_REG.
- Address wrap: none. Every address is valid.

Optional Feature:
- Macro: TDP_RAM_COLL_CNT_EN.
- When defined:
  - Adds output coll_cnt [15:0], a saturating count of coll events.
  - Reset to 0 by rst and by an accepted clr.
  - Holds at 16'hFFFF once reached.
- When undefined: the port is absent and coll behaviour is unchanged.

Test Plan:
- Reset-clear sweep (DATA_WIDTH=8, ADDR_WIDTH=6): release rst -> busy=1 for exactly 64 cycles. Afterwards, reading addr 0x00, 0x2A and 0x3F on both ports returns 0x00 with qv=1 one cycle after each request.
- Byte enables (DATA_WIDTH=32): write 0xAABBCCDD to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101 -> read returns 0xAA22CC44.
- Read-during-write: mem[3]=0x10, then port A writes 0x20 to addr 3. RDW_MODE=0 -> q_a=0x10, qv_a=1. Mode 1 -> q_a=0x20. Mode 2 -> q_a holds, qv_a=0. A following read returns 0x20 in all modes.
- Collision (DATA_WIDTH=16): port A writes 0x1111 with be=2'b01, port B writes 0x2222 with be=2'b11, both to addr 9 in the same cycle -> coll pulses once; mem[9]=0x2211. With the macro defined, coll_cnt=1.
- OUT_REG=1 latency: read addr 7 holding 0x5A -> q_a=0x5A and qv_a=1 exactly 2 edges after the request; back-to-back reads of addr 7, 8, 9 produce 3 consecutive valid cycles.
- clr mid-operation: write 0xFF to addr 12, pulse clr -> busy=1 for 64 cycles and a port B read issued meanwhile gives qv_b=0. Assert rst at sweep cycle 30 -> busy lasts 64 more cycles after release; afterwards mem[12]=0x00.
